// File: rtl/rd_ctrl.sv
// -----------------------------------------------------------------------------
// rd_ctrl -- read-side controller of a synchronous RAM-based FIFO.
//
// Reads words out of a RAM with a one-cycle registered read port and presents
// them on a valid/ready stream through a two-entry output buffer. The buffer
// absorbs the RAM read latency, so the stream can move one word per cycle
// while downstream keeps i_tready high.
//
// Parameters
//   ALEN : RAM address width. Pointers are ALEN+1 bits; the MSB is the wrap bit.
//   DLEN : data width.
//
// Ports
//   clk         : clock; all state changes on its rising edge
//   rst         : asynchronous, active-high reset
//   i_wptr      : write pointer from the write-side controller (same clock)
//   o_rptr      : read pointer, fed back to the write-side full logic
//   o_raddr     : RAM read address (o_rptr without the wrap bit)
//   o_ram_ren   : RAM read enable
//   i_ram_rdata : RAM read data, valid one cycle after o_ram_ren
//   o_tvalid    : stream valid
//   i_tready    : stream ready
//   o_tdata     : stream data (head of the output buffer)
//   o_level     : only with FIFO_RD_LEVEL_EN defined. Registered count of
//                 words still in the RAM plus words in flight plus words
//                 buffered.
//
// Build option: define FIFO_RD_LEVEL_EN to add o_level and its register.
// -----------------------------------------------------------------------------
module rd_ctrl #(
  parameter int ALEN = 8,
  parameter int DLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ALEN:0]   i_wptr,
  output logic [ALEN:0]   o_rptr,
  output logic [ALEN-1:0] o_raddr,
  output logic            o_ram_ren,
  input  logic [DLEN-1:0] i_ram_rdata,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [DLEN-1:0] o_tdata
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ALEN+1:0] o_level
`endif
);

  // Buffer occupancy; the encoding equals the word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t      r_state;
  buf_state_t      w_state_next;
  logic [ALEN:0]   r_rptr;
  logic            r_in_flight;
  logic            r_head;
  logic [DLEN-1:0] r_buf [2];

  logic            w_ram_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_tail;
  logic [1:0]      w_count;
  logic [2:0]      w_occupancy;

  assign w_ram_empty = (i_wptr == r_rptr);
  assign w_count     = r_state;
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_in_flight};
  assign w_push      = r_in_flight;
  assign w_pop       = o_tvalid & i_tready;
  // Tail slot sits one past the head only when exactly one word is held.
  assign w_tail      = r_head ^ (r_state == ONE);

  // A pop on this edge frees a buffer slot in time for the word being
  // requested now, so count it as free. Without that credit the stream
  // stalls every third cycle under continuous ready.
  assign o_ram_ren = ~rst & ~w_ram_empty & ((w_occupancy < 3'd2) | w_pop);

  assign o_rptr   = r_rptr;
  assign o_raddr  = r_rptr[ALEN-1:0];
  assign o_tvalid = (r_state != EMPTY);
  assign o_tdata  = r_buf[r_head];

  // Occupancy FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Occupancy FSM: next state. A push in TWO cannot happen because no read
  // is issued while the buffer plus the in-flight word would exceed two.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_next = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_next = TWO;
        else if (!w_push && w_pop) w_state_next = EMPTY;
      end
      TWO:     if (w_pop) w_state_next = ONE;
      default: w_state_next = EMPTY;
    endcase
  end

  // Read pointer, in-flight flag and buffer head. Clearing in_flight at
  // reset drops whatever read was outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr      <= '0;
      r_in_flight <= 1'b0;
      r_head      <= 1'b0;
    end else begin
      r_in_flight <= o_ram_ren;
      if (o_ram_ren) r_rptr <= r_rptr + 1'b1;
      if (w_pop)     r_head <= ~r_head;
    end
  end

  // Buffer storage; cleared at reset so o_tdata reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push && (w_tail == 1'(i))) r_buf[i] <= i_ram_rdata;
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ALEN:0]   w_ram_used;
  logic [ALEN+1:0] r_level;

  // Difference taken at pointer width so the wrap bit handles wrap-around.
  assign w_ram_used = i_wptr - r_rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      r_level <= {1'b0, w_ram_used} + {{ALEN{1'b0}}, w_count}
                 + {{(ALEN+1){1'b0}}, r_in_flight};
    end
  end

  assign o_level = r_level;
`endif

endmodule
